pipe_hazard_ctrl: RTL and testbench

Central stall/forward scheduler for the 5-stage MIPS pipeline. It generates the ID_Stall, EX_Stall and M_Stall hold signals that the ID/EX and EX/MEM pipeline registers sample, and the ID-stage forwarding selects. It also sequences the multi-cycle MUL/DIV unit, holding dependent instructions until HI/LO is valid.

---
 rtl/pipe_hazard_ctrl_if.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 72 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
// Stall-counter signals exist only when HAZARD_STATS_EN is defined.
interface pipe_hazard_ctrl_if;
    logic [4:0] ID_Rs, ID_Rt, EX_Rw, M_Rw;
    logic       ID_WantRs, ID_WantRt, ID_NeedRs, ID_NeedRt;
    logic       EX_RegWrite, EX_MemRead, EX_MulDiv, EX_IsDiv, EX_HiLoRead;
    logic       M_RegWrite, M_MemRead, M_MemStall, EXC_Flush;
    logic       ID_Stall, EX_Stall, M_Stall, ID_RsFwdSel, ID_RtFwdSel, MulDivBusy;
`ifdef HAZARD_STATS_EN
    logic [31:0] StallCntLoadUse, StallCntHiLo;
`endif
    modport master (
        output ID_Rs, ID_Rt, EX_Rw, M_Rw, ID_WantRs, ID_WantRt, ID_NeedRs, ID_NeedRt,
               EX_RegWrite, EX_MemRead, EX_MulDiv, EX_IsDiv, EX_HiLoRead,
               M_RegWrite, M_MemRead, M_MemStall, EXC_Flush,
        input  ID_Stall, EX_Stall, M_Stall, ID_RsFwdSel, ID_RtFwdSel, MulDivBusy
`ifdef HAZARD_STATS_EN
        , input StallCntLoadUse, StallCntHiLo
`endif
    );
    modport slave (
        input  ID_Rs, ID_Rt, EX_Rw, M_Rw, ID_WantRs, ID_WantRt, ID_NeedRs, ID_NeedRt,
               EX_RegWrite, EX_MemRead, EX_MulDiv, EX_IsDiv, EX_HiLoRead,
               M_RegWrite, M_MemRead, M_MemStall, EXC_Flush,
        output ID_Stall, EX_Stall, M_Stall, ID_RsFwdSel, ID_RtFwdSel, MulDivBusy
`ifdef HAZARD_STATS_EN
        , output StallCntLoadUse, StallCntHiLo
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/forward scheduler and HI/LO multi-cycle sequencer.
// Define HAZARD_STATS_EN to add load-use and HI/LO stall cycle counters.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input logic              CLK,
    input logic              RST,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic ex_rs, ex_rt, m_rs, m_rt, load_use, id_need, hilo_hold;
    logic busy, cnt_zero, m_stall, ex_stall, id_stall, accept;

    assign ex_rs = hz.EX_RegWrite && hz.EX_Rw != 5'd0 && hz.EX_Rw == hz.ID_Rs;
    assign ex_rt = hz.EX_RegWrite && hz.EX_Rw != 5'd0 && hz.EX_Rw == hz.ID_Rt;
    assign m_rs  = hz.M_RegWrite && hz.M_Rw != 5'd0 && hz.M_Rw == hz.ID_Rs;
    assign m_rt  = hz.M_RegWrite && hz.M_Rw != 5'd0 && hz.M_Rw == hz.ID_Rt;

    assign load_use = hz.EX_MemRead & ((ex_rs & (hz.ID_WantRs | hz.ID_NeedRs)) |
                                       (ex_rt & (hz.ID_WantRt | hz.ID_NeedRt)));
    assign id_need  = (ex_rs & hz.ID_NeedRs) | (ex_rt & hz.ID_NeedRt) |
                      (hz.M_MemRead & ((m_rs & hz.ID_NeedRs) | (m_rt & hz.ID_NeedRt)));

    assign busy      = state_q == BUSY;
    assign cnt_zero  = count_q == '0;
    // Last BUSY cycle (count==0) has HI/LO valid, so nothing waits on it.
    assign hilo_hold = busy & ~cnt_zero & (hz.EX_HiLoRead | hz.EX_MulDiv);
    assign m_stall   = hz.M_MemStall;
    assign ex_stall  = m_stall | hilo_hold;
    assign id_stall  = ex_stall | load_use | id_need;
    assign accept    = hz.EX_MulDiv & ~m_stall & ~hz.EXC_Flush & (~busy | cnt_zero);

    always_comb begin
        state_d = accept ? BUSY : ((busy & cnt_zero) ? IDLE : state_q);
        count_d = accept ? (hz.EX_IsDiv ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1))
                         : ((busy & ~cnt_zero) ? count_q - 1'b1 : count_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign hz.M_Stall     = ~RST & m_stall;
    assign hz.EX_Stall    = ~RST & ex_stall;
    assign hz.ID_Stall    = ~RST & id_stall;
    assign hz.ID_RsFwdSel = ~RST & ~id_stall & m_rs & ~hz.M_MemRead & hz.ID_NeedRs;
    assign hz.ID_RtFwdSel = ~RST & ~id_stall & m_rt & ~hz.M_MemRead & hz.ID_NeedRt;
    assign hz.MulDivBusy  = busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] lu_cnt_q, hl_cnt_q;
    always_ff @(posedge CLK) begin
        lu_cnt_q <= RST ? '0 : lu_cnt_q + {31'd0, load_use};
        hl_cnt_q <= RST ? '0 : hl_cnt_q + {31'd0, hilo_hold};
    end
    assign hz.StallCntLoadUse = lu_cnt_q;
    assign hz.StallCntHiLo    = hl_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks against a remaining-cycles model.
module tb_pipe_hazard_ctrl;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if hz();
    pipe_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (.CLK(CLK), .RST(RST), .hz(hz));

    int errs = 0, checks = 0;
    int rem = 0;
    int lu_cnt = 0, hl_cnt = 0;
    logic seen_ex_stall, seen_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic hit(input logic [4:0] rw, input logic we, input logic [4:0] r);
        return we && rw != 5'd0 && rw == r;
    endfunction

    task automatic idle();
        {hz.ID_Rs, hz.ID_Rt, hz.EX_Rw, hz.M_Rw} = '0;
        {hz.ID_WantRs, hz.ID_WantRt, hz.ID_NeedRs, hz.ID_NeedRt} = '0;
        {hz.EX_RegWrite, hz.EX_MemRead, hz.EX_MulDiv, hz.EX_IsDiv, hz.EX_HiLoRead} = '0;
        {hz.M_RegWrite, hz.M_MemRead, hz.M_MemStall, hz.EXC_Flush} = '0;
    endtask

    task automatic rand_in();
        hz.ID_Rs = 5'($urandom_range(0, 3));
        hz.ID_Rt = 5'($urandom_range(0, 3));
        hz.EX_Rw = 5'($urandom_range(0, 3));
        hz.M_Rw  = 5'($urandom_range(0, 3));
        {hz.ID_WantRs, hz.ID_WantRt, hz.ID_NeedRs, hz.ID_NeedRt} = 4'($urandom);
        hz.EX_RegWrite = 1'($urandom);
        hz.EX_MemRead  = 1'($urandom);
        hz.M_RegWrite  = 1'($urandom);
        hz.M_MemRead   = 1'($urandom);
        hz.EX_MulDiv   = $urandom_range(0, 5) == 0;
        hz.EX_IsDiv    = $urandom_range(0, 2) == 0;
        hz.EX_HiLoRead = $urandom_range(0, 3) == 0;
        hz.M_MemStall  = $urandom_range(0, 5) == 0;
        hz.EXC_Flush   = $urandom_range(0, 9) == 0;
        RST            = $urandom_range(0, 60) == 0;
    endtask

    // Inputs already driven; check combinational outputs, then advance one clock.
    task automatic cycle();
        logic [4:0] src [2];
        logic want [2], need [2], fw [2];
        logic lu, nd, hold, es, is, acc;
        int nxt;
        #1;
        src  = '{hz.ID_Rs, hz.ID_Rt};
        want = '{hz.ID_WantRs, hz.ID_WantRt};
        need = '{hz.ID_NeedRs, hz.ID_NeedRt};
        lu = 0;
        nd = 0;
        for (int i = 0; i < 2; i++) begin
            lu |= hz.EX_MemRead & hit(hz.EX_Rw, hz.EX_RegWrite, src[i]) & (want[i] | need[i]);
            nd |= need[i] & (hit(hz.EX_Rw, hz.EX_RegWrite, src[i]) |
                             (hz.M_MemRead & hit(hz.M_Rw, hz.M_RegWrite, src[i])));
        end
        hold = rem > 1 && (hz.EX_HiLoRead || hz.EX_MulDiv);
        es = hz.M_MemStall | hold;
        is = es | lu | nd;
        for (int i = 0; i < 2; i++)
            fw[i] = need[i] & hit(hz.M_Rw, hz.M_RegWrite, src[i]) & ~hz.M_MemRead & ~is;
        chk("M_Stall",  hz.M_Stall,     32'(!RST && hz.M_MemStall));
        chk("EX_Stall", hz.EX_Stall,    32'(!RST && es));
        chk("ID_Stall", hz.ID_Stall,    32'(!RST && is));
        chk("RsFwd",    hz.ID_RsFwdSel, 32'(!RST && fw[0]));
        chk("RtFwd",    hz.ID_RtFwdSel, 32'(!RST && fw[1]));
        seen_ex_stall = hz.EX_Stall;
        acc = hz.EX_MulDiv && !hz.M_MemStall && !hz.EXC_Flush && rem <= 1;
        nxt = RST ? 0 : acc ? (hz.EX_IsDiv ? 32 : 4) : (rem > 0 ? rem - 1 : 0);
        lu_cnt = RST ? 0 : lu_cnt + int'(lu);
        hl_cnt = RST ? 0 : hl_cnt + int'(hold);
        @(posedge CLK);
        #1;
        rem = nxt;
        chk("MulDivBusy", hz.MulDivBusy, 32'(rem > 0));
        seen_busy = hz.MulDivBusy;
`ifdef HAZARD_STATS_EN
        chk("StallCntLoadUse", hz.StallCntLoadUse, 32'(lu_cnt));
        chk("StallCntHiLo",    hz.StallCntHiLo,    32'(hl_cnt));
`endif
        @(negedge CLK);
    endtask

    initial begin
        int n_stall, n_busy;
        idle();
        RST = 1;
        @(negedge CLK);
        cycle();
        cycle();
        RST = 0;
        // load-use: lw $8 in EX, add using $8 in ID
        hz.EX_Rw = 8; hz.EX_RegWrite = 1; hz.EX_MemRead = 1; hz.ID_Rs = 8; hz.ID_WantRs = 1;
        cycle();
        chk("lu_id_stall", 32'(seen_ex_stall), 32'd0);
        idle();
        hz.M_Rw = 8; hz.M_RegWrite = 1; hz.M_MemRead = 1; hz.ID_Rs = 8; hz.ID_WantRs = 1;
        #1 chk("lu_release", {hz.ID_Stall, hz.ID_RsFwdSel}, 32'd0);
        cycle();
        // beq after ALU op: stall, then forward from MEM
        idle();
        hz.EX_Rw = 9; hz.EX_RegWrite = 1; hz.ID_Rt = 9; hz.ID_NeedRt = 1;
        #1 chk("br_stall", hz.ID_Stall, 32'd1);
        cycle();
        idle();
        hz.M_Rw = 9; hz.M_RegWrite = 1; hz.ID_Rt = 9; hz.ID_NeedRt = 1;
        #1 chk("br_fwd", {hz.ID_Stall, hz.ID_RtFwdSel}, 32'd1);
        cycle();
        // $0 destination never stalls
        idle();
        hz.EX_RegWrite = 1; hz.EX_MemRead = 1; hz.ID_WantRs = 1;
        #1 chk("zero_reg", hz.ID_Stall, 32'd0);
        cycle();
        // DIV then MFLO
        idle();
        hz.EX_MulDiv = 1; hz.EX_IsDiv = 1;
        cycle();
        n_busy = int'(seen_busy);
        n_stall = 0;
        idle();
        hz.EX_HiLoRead = 1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_stall += int'(seen_ex_stall);
            n_busy += int'(seen_busy);
        end
        chk("div_hold_cycles", 32'(n_stall), 32'd31);
        chk("div_busy_cycles", 32'(n_busy), 32'd32);
        // MULT waits behind a memory stall
        idle();
        hz.EX_MulDiv = 1; hz.M_MemStall = 1;
        for (int i = 0; i < 3; i++) cycle();
        chk("mul_no_accept", 32'(seen_busy), 32'd0);
        hz.M_MemStall = 0;
        cycle();
        chk("mul_accept", 32'(seen_busy), 32'd1);
        // flush does not abort; reset does
        idle();
        hz.EXC_Flush = 1;
        cycle();
        idle();
        RST = 1;
        cycle();
        chk("rst_abort", 32'(seen_busy), 32'd0);
        RST = 0;
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
